// File: rtl/pla_prog_eval.sv
// pla_prog_eval: programmable sum-of-products evaluator, two-stage valid/ready pipeline.
module pla_prog_eval #(
  parameter int N_IN    = 32,
  parameter int N_OUT   = 20,
  parameter int N_TERMS = 64,
  parameter int AW      = $clog2(N_TERMS),
  parameter int CW      = $clog2(N_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [N_IN-1:0]  in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [N_OUT-1:0] out_data_o,
  output logic [CW-1:0]    out_hits_o,
  input  logic             cfg_we_i,
  input  logic [AW-1:0]    cfg_addr_i,
  input  logic [N_IN-1:0]  cfg_care_i,
  input  logic [N_IN-1:0]  cfg_value_i,
  input  logic [N_OUT-1:0] cfg_omask_i,
  input  logic             cfg_en_i,
  input  logic             cfg_clear_i,
  input  logic             cfg_pol_we_i,
  input  logic [N_OUT-1:0] cfg_pol_i
);
  logic [N_IN-1:0]    care_q  [N_TERMS];
  logic [N_IN-1:0]    value_q [N_TERMS];
  logic [N_OUT-1:0]   omask_q [N_TERMS];
  logic [N_TERMS-1:0] en_q, en_d, match_d, match_q;
  logic [N_OUT-1:0]   pol_q, or_d, or_q, out_data_q;
  logic [CW-1:0]      hits_d, out_hits_q;
  logic               s1_valid_q, out_valid_q, s2_load, s1_adv, addr_ok;

  assign addr_ok     = {1'b0, cfg_addr_i} < (AW+1)'(N_TERMS);
  assign s2_load     = !out_valid_q || out_ready_i;
  assign s1_adv      = !s1_valid_q || s2_load;
  assign in_ready_o  = s1_adv;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_hits_o  = out_hits_q;

  always_comb begin
    en_d = cfg_clear_i ? '0 : en_q;
    if (cfg_we_i && addr_ok) en_d[cfg_addr_i] = cfg_en_i;
    match_d = '0;
    or_d    = '0;
    hits_d  = '0;
    for (int t = 0; t < N_TERMS; t++) begin
      match_d[t] = en_q[t] && (((in_data_i ^ value_q[t]) & care_q[t]) == '0);
      or_d       = or_d | (match_d[t] ? omask_q[t] : '0);
      hits_d     = hits_d + CW'(match_q[t]);
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_we_i && addr_ok) begin
      care_q[cfg_addr_i]  <= cfg_care_i;
      value_q[cfg_addr_i] <= cfg_value_i;
      omask_q[cfg_addr_i] <= cfg_omask_i;
    end
  end

  // OR-plane result is frozen with the matches so later omask writes cannot reach a captured vector
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid_i) begin
      match_q <= match_d;
      or_q    <= or_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q        <= '0;
      pol_q       <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_hits_q  <= '0;
    end else begin
      en_q <= en_d;
      if (cfg_pol_we_i) pol_q <= cfg_pol_i;
      if (s1_adv) s1_valid_q <= in_valid_i;
      if (s2_load) out_valid_q <= s1_valid_q;
      if (s2_load && s1_valid_q) begin
        out_data_q <= pol_q ^ or_q;
        out_hits_q <= hits_d;
      end
    end
  end
endmodule
